// File: rtl/claw_pkg.sv
// claw_pkg: shared types and constants for the claw machine game sequencer.
//   claw_state_e : sequencer states; the encodings are what state_o reports.
//   DIR_*        : gantry (left/right) motor direction codes.
//   CLAW_*       : claw (front) motor direction codes.
//   max3         : helper used to size the phase counter.
package claw_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PLAY  = 3'd1,
    ST_DROP  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_RAISE = 3'd4,
    ST_DONE  = 3'd5
  } claw_state_e;

  localparam logic [1:0] DIR_FWD    = 2'b10;
  localparam logic [1:0] DIR_REV    = 2'b01;
  localparam logic [1:0] DIR_STOP   = 2'b00;

  localparam logic [1:0] CLAW_LOWER = 2'b01;
  localparam logic [1:0] CLAW_RAISE = 2'b10;
  localparam logic [1:0] CLAW_HOLD  = 2'b00;
  localparam logic [1:0] CLAW_BRAKE = 2'b11;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/claw_game_ctrl_if.sv
// claw_game_ctrl_if: groups the keyboard/coin inputs and motor/status outputs
// of the claw game sequencer.
//   coin_pulse, key_valid, key_up, key_dn, key_drop : into the sequencer
//   lr_dir[1:0], claw_dir[1:0]                       : motor direction codes
//   state_o[2:0], credits[3:0], busy, done_pulse     : status
// Modports: master = stimulus/top-level side, slave = the sequencer.
interface claw_game_ctrl_if;

  logic       coin_pulse;
  logic       key_valid;
  logic       key_up;
  logic       key_dn;
  logic       key_drop;
  logic [1:0] lr_dir;
  logic [1:0] claw_dir;
  logic [2:0] state_o;
  logic [3:0] credits;
  logic       busy;
  logic       done_pulse;

  modport master (
    output coin_pulse, key_valid, key_up, key_dn, key_drop,
    input  lr_dir, claw_dir, state_o, credits, busy, done_pulse
  );

  modport slave (
    input  coin_pulse, key_valid, key_up, key_dn, key_drop,
    output lr_dir, claw_dir, state_o, credits, busy, done_pulse
  );

endinterface

// File: rtl/claw_tick_gen.sv
// claw_tick_gen: timing prescaler. Emits a one-cycle tick every TICK_DIV
// clock cycles; clr restarts the count so the next tick comes TICK_DIV
// cycles after the clearing edge.
//   clk   : system clock
//   reset : asynchronous, active-high
//   clr   : synchronous restart of the prescaler
//   tick  : high for one cycle at the end of each TICK_DIV-cycle period
module claw_tick_gen #(
  parameter int unsigned TICK_DIV = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt_q;

  assign tick = (cnt_q == CW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/claw_game_ctrl.sv
// claw_game_ctrl: claw machine game sequencer. Counts credits from coin
// pulses, jogs the gantry on UP/DOWN keys during play, runs the automatic
// drop / hold / raise grab sequence on SPACE and brakes for one cycle at
// the end of the round.
//   clk, reset : system clock, asynchronous active-high reset
//   bus        : claw_game_ctrl_if.slave (keys/coin in, motor codes/status out)
// Optional feature: define CLAW_PLAY_TIMEOUT_EN to force a drop PLAY_MS
// ticks after entering PLAY; otherwise PLAY waits for the drop key.
module claw_game_ctrl
  import claw_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 100000,
  parameter int unsigned JOG_MS     = 100,
  parameter int unsigned DROP_MS    = 750,
  parameter int unsigned HOLD_MS    = 1250,
  parameter int unsigned RAISE_MS   = 750,
  parameter int unsigned PLAY_MS    = 20000,
  parameter int unsigned MAX_CREDIT = 9
) (
  input  logic             clk,
  input  logic             reset,
  claw_game_ctrl_if.slave  bus
);

  localparam int unsigned PH_W  = $clog2(max3(DROP_MS, HOLD_MS, RAISE_MS)) + 1;
  localparam int unsigned JOG_W = $clog2(JOG_MS + 1);

  if (TICK_DIV < 2) begin : g_bad_tick_div
    $error("claw_game_ctrl: TICK_DIV must be at least 2");
  end
  if (MAX_CREDIT > 15) begin : g_bad_max_credit
    $error("claw_game_ctrl: MAX_CREDIT must fit in 4 bits");
  end
  if (PLAY_MS == 0) begin : g_bad_play_ms
    $error("claw_game_ctrl: PLAY_MS must be nonzero");
  end

  claw_state_e       state_q, state_d;
  logic [3:0]        credits_q, credits_d;
  logic [1:0]        lr_q, lr_d;
  logic [JOG_W-1:0]  jog_q, jog_d;
  logic [PH_W-1:0]   ph_q;
  logic              tick;
  logic              presc_clr;
  logic              consume;
  logic              play_expired;

  // Any state change restarts the prescaler, so every timed phase begins on
  // a fresh tick period and the prescaler free-runs from PLAY entry.
  assign presc_clr = (state_d != state_q);

  claw_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (presc_clr),
    .tick  (tick)
  );

`ifdef CLAW_PLAY_TIMEOUT_EN
  localparam int unsigned PT_W = $clog2(PLAY_MS + 1);

  logic [PT_W-1:0] play_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      play_q <= '0;
    end else if (state_q != ST_PLAY) begin
      play_q <= '0;
    end else if (tick) begin
      play_q <= play_q + 1'b1;
    end
  end

  assign play_expired = (state_q == ST_PLAY) && tick &&
                        (play_q == PT_W'(PLAY_MS - 1));
`else
  assign play_expired = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (credits_q != '0) state_d = ST_PLAY;
      ST_PLAY:  if ((bus.key_valid && bus.key_drop) || play_expired) state_d = ST_DROP;
      ST_DROP:  if (tick && ph_q == PH_W'(DROP_MS - 1))  state_d = ST_HOLD;
      ST_HOLD:  if (tick && ph_q == PH_W'(HOLD_MS - 1))  state_d = ST_RAISE;
      ST_RAISE: if (tick && ph_q == PH_W'(RAISE_MS - 1)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Credits: a coin and a consume in the same cycle cancel, even at the cap.
  assign consume = (state_q == ST_IDLE) && (credits_q != '0);

  always_comb begin
    credits_d = credits_q;
    if (bus.coin_pulse && !consume && credits_q != 4'(MAX_CREDIT)) begin
      credits_d = credits_q + 1'b1;
    end else if (!bus.coin_pulse && consume) begin
      credits_d = credits_q - 1'b1;
    end
  end

  // Gantry jog. Leaving PLAY (including by key_drop) wins over any jog key.
  always_comb begin
    lr_d  = lr_q;
    jog_d = jog_q;
    if (state_d != ST_PLAY) begin
      lr_d  = DIR_STOP;
      jog_d = '0;
    end else if (state_q == ST_PLAY && bus.key_valid && bus.key_up) begin
      lr_d  = DIR_FWD;
      jog_d = JOG_W'(JOG_MS);
    end else if (state_q == ST_PLAY && bus.key_valid && bus.key_dn) begin
      lr_d  = DIR_REV;
      jog_d = JOG_W'(JOG_MS);
    end else if (tick && jog_q != '0) begin
      jog_d = jog_q - 1'b1;
      if (jog_q == JOG_W'(1)) lr_d = DIR_STOP;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      credits_q <= '0;
      lr_q      <= DIR_STOP;
      jog_q     <= '0;
      ph_q      <= '0;
    end else begin
      state_q   <= state_d;
      credits_q <= credits_d;
      lr_q      <= lr_d;
      jog_q     <= jog_d;
      if (presc_clr) begin
        ph_q <= '0;
      end else if (tick && (state_q == ST_DROP || state_q == ST_HOLD ||
                            state_q == ST_RAISE)) begin
        ph_q <= ph_q + 1'b1;
      end
    end
  end

  always_comb begin
    case (state_q)
      ST_DROP:  bus.claw_dir = CLAW_LOWER;
      ST_RAISE: bus.claw_dir = CLAW_RAISE;
      ST_DONE:  bus.claw_dir = CLAW_BRAKE;
      default:  bus.claw_dir = CLAW_HOLD;
    endcase
  end

  assign bus.lr_dir     = lr_q;
  assign bus.state_o    = state_q;
  assign bus.credits    = credits_q;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.done_pulse = (state_q == ST_DONE);

endmodule

// File: tb/tb_claw_game_ctrl.sv
// tb_claw_game_ctrl: directed self-checking bench for claw_game_ctrl with
// TICK_DIV=4, JOG_MS=3, DROP_MS=2, HOLD_MS=3, RAISE_MS=2, PLAY_MS=10,
// MAX_CREDIT=9. Honours CLAW_PLAY_TIMEOUT_EN for the play-timeout check.
module tb_claw_game_ctrl;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   n;
  bit   ok;

  claw_game_ctrl_if bus ();

  claw_game_ctrl #(
    .TICK_DIV   (4),
    .JOG_MS     (3),
    .DROP_MS    (2),
    .HOLD_MS    (3),
    .RAISE_MS   (2),
    .PLAY_MS    (10),
    .MAX_CREDIT (9)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.coin_pulse = 1'b0;
    bus.key_valid  = 1'b0;
    bus.key_up     = 1'b0;
    bus.key_dn     = 1'b0;
    bus.key_drop   = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic key(input bit up, input bit dn, input bit drop);
    bus.key_valid = 1'b1;
    bus.key_up    = up;
    bus.key_dn    = dn;
    bus.key_drop  = drop;
    step();
    bus.key_valid = 1'b0;
    bus.key_up    = 1'b0;
    bus.key_dn    = 1'b0;
    bus.key_drop  = 1'b0;
  endtask

  task automatic coin_to_play();
    bus.coin_pulse = 1'b1;
    step();
    bus.coin_pulse = 1'b0;
    step();
  endtask

  task automatic run_len(input logic [1:0] v, input bit is_claw, output int len);
    len = 0;
    while (((is_claw ? bus.claw_dir : bus.lr_dir) === v) && len < 100) begin
      len++;
      step();
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int limit, output bit reached);
    int i;
    reached = 1'b0;
    i = 0;
    while (!reached && i < limit) begin
      if (bus.state_o === s) reached = 1'b1;
      else begin
        step();
        i++;
      end
    end
  endtask

  initial begin
    // Reset values
    do_reset();
    chk("rst_lr", bus.lr_dir, 0);
    chk("rst_claw", bus.claw_dir, 0);
    chk("rst_state", bus.state_o, 0);
    chk("rst_credits", bus.credits, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done_pulse, 0);

    // Coin, play, full grab sequence
    bus.coin_pulse = 1'b1;
    step();
    bus.coin_pulse = 1'b0;
    chk("coin_credits", bus.credits, 1);
    chk("coin_state", bus.state_o, 0);
    step();
    chk("play_state", bus.state_o, 1);
    chk("play_credits", bus.credits, 0);
    chk("play_busy", bus.busy, 1);
    repeat (4) step();
    key(1'b0, 1'b0, 1'b1);
    chk("drop_state", bus.state_o, 2);
    chk("drop_claw", bus.claw_dir, 1);
    chk("drop_lr", bus.lr_dir, 0);
    run_len(2'b01, 1'b1, n);
    chk("drop_len", n, 8);
    chk("hold_state", bus.state_o, 3);
    run_len(2'b00, 1'b1, n);
    chk("hold_len", n, 12);
    chk("raise_state", bus.state_o, 4);
    run_len(2'b10, 1'b1, n);
    chk("raise_len", n, 8);
    chk("done_claw", bus.claw_dir, 3);
    chk("done_pulse", bus.done_pulse, 1);
    chk("done_state", bus.state_o, 5);
    step();
    chk("end_state", bus.state_o, 0);
    chk("end_credits", bus.credits, 0);
    chk("end_done", bus.done_pulse, 0);
    chk("end_busy", bus.busy, 0);
    chk("end_claw", bus.claw_dir, 0);

    // Credit saturation and coin/consume in the same cycle
    do_reset();
    coin_to_play();
    bus.coin_pulse = 1'b1;
    repeat (12) step();
    bus.coin_pulse = 1'b0;
    chk("sat_credits", bus.credits, 9);
    key(1'b0, 1'b0, 1'b1);
    wait_state(3'd5, 60, ok);
    chk("sat_reach_done", ok, 1);
    step();
    chk("sat_idle_state", bus.state_o, 0);
    chk("sat_idle_credits", bus.credits, 9);
    bus.coin_pulse = 1'b1;
    step();
    bus.coin_pulse = 1'b0;
    chk("coin_consume_state", bus.state_o, 1);
    chk("coin_consume_credits", bus.credits, 9);

    // Gantry jog, direction override with reload, drop beats jog key
    do_reset();
    coin_to_play();
    key(1'b1, 1'b0, 1'b0);
    run_len(2'b10, 1'b0, n);
    chk("jog_up_len_in_range", (n >= 8 && n <= 12), 1);
    chk("jog_up_stop", bus.lr_dir, 0);
    chk("jog_up_state", bus.state_o, 1);
    key(1'b1, 1'b0, 1'b0);
    chk("jog_up2_lr", bus.lr_dir, 2);
    repeat (3) step();
    key(1'b0, 1'b1, 1'b0);
    chk("jog_dn_lr", bus.lr_dir, 1);
    run_len(2'b01, 1'b0, n);
    chk("jog_dn_len_in_range", (n >= 8 && n <= 12), 1);
    chk("jog_dn_stop", bus.lr_dir, 0);
    key(1'b1, 1'b0, 1'b1);
    chk("up_drop_state", bus.state_o, 2);
    chk("up_drop_lr", bus.lr_dir, 0);

    // Asynchronous reset during HOLD
    do_reset();
    bus.coin_pulse = 1'b1;
    step();
    step();
    bus.coin_pulse = 1'b0;
    chk("two_coin_state", bus.state_o, 1);
    chk("two_coin_credits", bus.credits, 1);
    key(1'b0, 1'b0, 1'b1);
    wait_state(3'd3, 40, ok);
    chk("reach_hold", ok, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_state", bus.state_o, 0);
    chk("arst_credits", bus.credits, 0);
    chk("arst_claw", bus.claw_dir, 0);
    chk("arst_lr", bus.lr_dir, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_done", bus.done_pulse, 0);

    // Play timeout
    do_reset();
    coin_to_play();
    n = 0;
`ifdef CLAW_PLAY_TIMEOUT_EN
    while (bus.state_o === 3'd1 && n < 300) begin
      n++;
      step();
    end
    chk("timeout_len", n, 40);
    chk("timeout_state", bus.state_o, 2);
`else
    while (bus.state_o === 3'd1 && n < 200) begin
      n++;
      step();
    end
    chk("no_timeout_len", n, 200);
    chk("no_timeout_state", bus.state_o, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/claw_game_ctrl.md
# claw_game_ctrl

Game sequencer for the claw machine. It takes coin pulses and decoded keyboard events and produces the two-bit direction codes for the gantry (left/right) and claw (front) motor drivers. It owns the credit count, the timed jog of the gantry, the automatic drop/hold/raise grab sequence and the end-of-round brake. It sits between the keyboard decoder / coin debouncer and the motor PWM drivers, replacing ad-hoc sequencing in the top level.

## Interface
- TICK_DIV, 100000: clk cycles per timing tick (1 ms at 100 MHz); must be ≥2
- JOG_MS, 100: gantry jog length per key event, in ticks
- DROP_MS, 750: claw lowering phase, ticks
- HOLD_MS, 1250: claw dwell at bottom, ticks
- RAISE_MS, 750: claw raising phase, ticks
- PLAY_MS, 20000: play window before forced drop, ticks (used only with timeout feature)
- MAX_CREDIT, 9: credit saturation value, ≤15
- clk  in  1  system clock; one clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; clears every register
- coin_pulse  in  1  single-cycle pulse per coin (already debounced and one-pulsed)
- key_valid  in  1  single-cycle strobe; key_* below sampled only when high
- key_up / key_dn / key_drop  in  1 each  key-down levels for UP, DOWN, SPACE
- lr_dir  out  2  gantry code: 10 forward, 01 reverse, 00 stop
- claw_dir  out  2  claw code: 01 lower, 10 raise, 00 hold, 11 brake
- state_o  out  3  current state encoding (for 7-seg/LED)
- credits  out  4  current credit count
- busy  out  1  high in any state except IDLE
- done_pulse  out  1  high for exactly the DONE cycle

## Operation
- States: IDLE, PLAY, DROP, HOLD, RAISE, DONE.
- Credits: coin_pulse adds 1, saturating at MAX_CREDIT. IDLE with credits≠0 → PLAY, credits−1. Coin and consume in the same cycle: net unchanged.
- PLAY: on key_valid, priority key_drop > key_up > key_dn. key_drop → DROP. key_up → lr_dir=10, jog counter loaded with JOG_MS. key_dn → lr_dir=01, same load. A new jog key overrides direction and reloads. Jog counter decrements per tick; at 0 lr_dir=00. First tick of a jog may be partial (jog length JOG_MS−1 to JOG_MS ticks).
- DROP: claw_dir=01 for DROP_MS ticks → HOLD (00, HOLD_MS) → RAISE (10, RAISE_MS) → DONE.
- DONE: claw_dir=11 for one cycle, done_pulse=1, → IDLE.
- lr_dir forced 00 and jog counter cleared in every state except PLAY. key_valid is ignored outside PLAY.
- state_o: IDLE 0, PLAY 1, DROP 2, HOLD 3, RAISE 4, DONE 5. Codes 6 and 7 are unreachable; if reached, the next cycle is IDLE.

## Timing
- Reset values: state IDLE, lr_dir 00, claw_dir 00, credits 0, busy 0, done_pulse 0, all counters 0.
- All outputs are registered or decoded from registered state only. There is no combinational input→output path.
- coin_pulse at cycle n → credits=1 at n+1 → state PLAY at n+2 with credits=0.
- key_valid+key_drop at cycle n in PLAY → state DROP and claw_dir=01 at n+1.
- Tick prescaler and phase counter are cleared on entry to DROP, HOLD and RAISE, so each phase lasts exactly DUR×TICK_DIV cycles. In PLAY, the prescaler free-runs from PLAY entry.
- Phase counter width is $clog2 of the largest duration plus 1. Exit condition is tick && phase_cnt==DUR−1.
- Asynchronous reset mid-sequence returns all outputs to reset values immediately. Credits are lost.

## Configuration
- CLAW_PLAY_TIMEOUT_EN defined: the play timer counts ticks from PLAY entry. When it reaches PLAY_MS, the state goes to DROP even without a key. A key_drop in the same cycle gives the same result.
- Not defined: no play timer is instantiated, and PLAY waits indefinitely for key_drop.

## Structure
- Package claw_pkg holds:
  - the state enum and its encodings
  - the direction constants DIR_FWD=10, DIR_REV=01, DIR_STOP=00, CLAW_LOWER=01, CLAW_RAISE=10, CLAW_HOLD=00, CLAW_BRAKE=11
- Sub-module claw_tick_gen: prescaler with synchronous clear input, emits a 1-cycle tick every TICK_DIV cycles.

## Test plan
Bench parameters: TICK_DIV=4, JOG_MS=3, DROP_MS=2, HOLD_MS=3, RAISE_MS=2, PLAY_MS=10, MAX_CREDIT=9.
- Coin then key_drop 5 cycles after PLAY entry → claw_dir=01 for 8 cycles, 00 for 12, 10 for 8, 11 with done_pulse for 1, then IDLE with credits=0.
- 12 coin pulses in IDLE-blocked state (held in PLAY) → credits saturate at 9; coin and IDLE consume in the same cycle → credits unchanged.
- key_up in PLAY → lr_dir=10 for 8–12 cycles, then 00. key_dn mid-jog → lr_dir=01 the next cycle, with the counter reloaded.
- key_up and key_drop in the same key_valid → DROP, with lr_dir=00 the next cycle.
- Assert reset during HOLD → all outputs 0 immediately, state_o=0, credits=0.
- With CLAW_PLAY_TIMEOUT_EN and no keys → DROP entered 40 cycles after PLAY entry. Without the macro → state stays PLAY for 200 cycles.
